arith_operator_core: RTL and testbench
======================================

Name: arith_operator_core

Overview:
- Registered 16-bit arithmetic core that computes three results from one operand pair in parallel:
  - fixed-point sum;
  - fixed-point product;
  - half-precision floating-point sum.
- Sits behind the operand-entry logic and feeds the display/result mux.
- Each result has its own overflow flag.
- Latency is one clock.

Parameters:
- None. All widths are fixed (16-bit operands).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands valid this cycle; launches a computation
- num1  in  16  operand A (Q8.8 fixed, or binary16 float)
- num2  in  16  operand B (same interpretation as num1)
- out_valid  out  1  results valid (in_valid delayed one cycle)
- fix_sum  out  16  Q8.8 sum
- fix_prod  out  16  Q8.8 product
- flo_sum  out  16  binary16 sum
- overflow  out  3  [0] fixed add, [1] fixed multiply, [2] float add

Behaviour:
- Reset:
  - One synchronous cycle with rst=1 clears every output (results, overflow, out_valid) to 0.
  - rst overrides a simultaneous in_valid; any in-flight result is discarded.
- Timing:
  - On a clk edge with in_valid=1, all three results and their flags are registered; out_valid=1 in the next cycle.
  - With in_valid=0, the result registers hold their value and out_valid=0.
  - Back-to-back in_valid is allowed (throughput 1 per cycle).
- Fixed format: two's-complement Q8.8 (bits [15:8] integer incl. sign, bits [7:0] fraction).
- fix_sum:
  - 16-bit wrap-around add.
  - overflow[0] = 1 when both operands have the same sign and the result sign differs.
- fix_prod:
  - Full 32-bit signed product P; result = P[23:8] (arithmetic truncation toward minus infinity).
  - overflow[1] = 1 when P[31:23] is not all-equal.
- Float format: IEEE binary16 (sign[15], exp[14:10] bias 15, frac[9:0]).
- flo_sum:
  - Subnormal inputs (exp=0) are treated as zero.
  - Align the smaller-exponent mantissa (hidden 1) by right shift; shifts of 12 or more give zero contribution.
  - Add or subtract by sign, normalise, truncate (no rounding).
  - An exact-zero result is +0 (0x0000).
  - A result exponent at or below 0 flushes to +0, with overflow[2]=0.
  - A result exponent of 31 or more, or either input exponent equal to 31, gives sign|0x7C00 with overflow[2]=1.
  - If exactly one input is zero, flo_sum is the other input verbatim.

Optional Feature:
- Macro: SATURATE_EN.
- Defined:
  - On overflow[0] or overflow[1], the fixed result saturates to 0x7FFF (true result positive) or 0x8000 (true result negative).
  - Overflow flags are still asserted.
- Undefined: the wrap/truncate behaviour above applies.
- Float behaviour is unaffected either way.

Decomposition:
- Package arith_pkg:
  - constants W=16, FIX_FRAC=8, EXP_W=5, FRAC_W=10, EXP_BIAS=15, EXP_MAX=31;
  - overflow bit-index constants OVF_FIXA=0, OVF_FIXM=1, OVF_FLOA=2.
- One combinational sub-module, float_add_core: unpack, align, add/sub, normalise, pack, overflow.
- Fixed add and fixed multiply are inline in the top.

Test Plan:
- num1=0x001B, num2=0x002A (27, 42) -> fix_sum=0x0045, fix_prod=0x0004, overflow[1:0]=0, out_valid one cycle after in_valid.
- num1=0x0231, num2=0x009E (561, 158) -> fix_sum=0x02CF, fix_prod=0x015A, overflow[1:0]=0.
- num1=0x7F00, num2=0x0100:
  - fix_sum=0x8000 with overflow[0]=1 (0x7FFF under SATURATE_EN);
  - num1=0xFF00, num2=0x0200 -> fix_prod=0xFE00 with overflow[1]=0.
- Float sums:
  - 0x3C00+0x3C00 -> flo_sum=0x4000;
  - 0x3C00+0x3800 -> 0x3E00;
  - 0x3C00+0xBC00 -> 0x0000;
  - overflow[2]=0 in all three cases.
- Float overflow: 0x7BFF+0x7BFF -> flo_sum=0x7C00, overflow[2]=1; input 0x7C00 plus anything -> overflow[2]=1.
- Reset checks:
  - rst asserted with in_valid=1 -> next cycle all outputs 0 and out_valid=0;
  - in_valid=0 -> results hold the prior values.

Source files
------------

// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared widths, format constants and overflow-flag bit positions for the
// arithmetic operator core. Also carries the binary16 field layout used by the
// float adder.
// -----------------------------------------------------------------------------
package arith_pkg;

    localparam int W        = 16;   // operand / result width
    localparam int FIX_FRAC = 8;    // Q8.8 fraction bits
    localparam int EXP_W    = 5;    // binary16 exponent width
    localparam int FRAC_W   = 10;   // binary16 stored fraction width
    localparam int EXP_BIAS = 15;
    localparam int EXP_MAX  = 31;

    // Bit positions inside the 3-bit overflow vector
    localparam int OVF_FIXA = 0;
    localparam int OVF_FIXM = 1;
    localparam int OVF_FLOA = 2;

    localparam logic [W-1:0] FP_INF      = 16'h7C00;
    localparam logic [W-1:0] FIX_POS_MAX = 16'h7FFF;
    localparam logic [W-1:0] FIX_NEG_MAX = 16'h8000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

endpackage : arith_pkg

// File: rtl/float_add_core.sv
// -----------------------------------------------------------------------------
// float_add_core
// Combinational binary16 adder: unpack, align, add/subtract, normalise,
// truncate, pack. Subnormal inputs count as zero, results that underflow are
// flushed to +0, and results (or inputs) at exponent 31 become signed infinity
// with the overflow flag set.
//
// Ports:
//   a_i   [15:0]  operand A (binary16)
//   b_i   [15:0]  operand B (binary16)
//   sum_o [15:0]  truncated binary16 sum
//   ovf_o         float-add overflow
// -----------------------------------------------------------------------------
module float_add_core
    import arith_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    // Guard bits wide enough that any alignment shift below 12 stays exact,
    // so the only precision loss is the final truncation.
    localparam int GUARD_W = 12;
    localparam int MANT_W  = FRAC_W + 1;
    localparam int ALN_W   = MANT_W + GUARD_W;   // 23
    localparam int SUM_W   = ALN_W + 1;          // 24, room for the carry
    // Exponent correction: a leading one at bit SUM_W-2 means no change.
    localparam logic signed [7:0] LEAD_REF  = 8'(SUM_W - 2);
    localparam logic signed [7:0] EXP_TOP_S = 8'(EXP_MAX);
    localparam logic [EXP_W-1:0]  EXP_ALL1  = EXP_W'(EXP_MAX);

    fp16_t a, b, big, sml;
    logic  a_zero, b_zero, a_bigger, eff_sub, inf_sign;

    logic [EXP_W-1:0] exp_diff;
    logic [ALN_W-1:0] big_m, sml_al;
    logic [SUM_W-1:0] mag, norm;
    logic [4:0]       lead_pos;
    logic signed [7:0] res_exp;
    logic [FRAC_W-1:0] res_frac;
    logic              norm_unused;

    assign a = fp16_t'(a_i);
    assign b = fp16_t'(b_i);

    assign a_zero = (a.exp == '0);
    assign b_zero = (b.exp == '0);

    // Order by magnitude so the subtraction never goes negative
    assign a_bigger = ({a.exp, a.frac} >= {b.exp, b.frac});
    assign big      = a_bigger ? a : b;
    assign sml      = a_bigger ? b : a;
    assign eff_sub  = a.sign ^ b.sign;

    assign exp_diff = big.exp - sml.exp;
    assign big_m    = {1'b1, big.frac, {GUARD_W{1'b0}}};
    assign sml_al   = (exp_diff >= 5'd12) ? '0
                                          : ({1'b1, sml.frac, {GUARD_W{1'b0}}} >> exp_diff);

    assign mag = eff_sub ? ({1'b0, big_m} - {1'b0, sml_al})
                         : ({1'b0, big_m} + {1'b0, sml_al});

    // Leading-one detector: highest set bit wins
    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < SUM_W; i++) begin
            if (mag[i]) lead_pos = 5'(i);
        end
    end

    assign norm        = mag << (5'(SUM_W - 1) - lead_pos);
    assign res_frac    = norm[SUM_W-2 -: FRAC_W];
    assign norm_unused = ^{norm[SUM_W-1], norm[SUM_W-2-FRAC_W:0]};

    assign res_exp = $signed({3'b000, big.exp}) + $signed({3'b000, lead_pos}) - LEAD_REF;

    // Infinity inherits the sign of whichever input was already at exponent 31
    assign inf_sign = (a.exp == EXP_ALL1) ? a.sign : b.sign;

    always_comb begin
        sum_o = '0;
        ovf_o = 1'b0;
        if (a.exp == EXP_ALL1 || b.exp == EXP_ALL1) begin
            sum_o = FP_INF | {inf_sign, {(W-1){1'b0}}};
            ovf_o = 1'b1;
        end else if (a_zero && b_zero) begin
            sum_o = '0;
        end else if (a_zero) begin
            sum_o = b_i;
        end else if (b_zero) begin
            sum_o = a_i;
        end else if (mag == '0) begin
            sum_o = '0;
        end else if (res_exp <= 8'sd0) begin
            sum_o = '0;
        end else if (res_exp >= EXP_TOP_S) begin
            sum_o = FP_INF | {big.sign, {(W-1){1'b0}}};
            ovf_o = 1'b1;
        end else begin
            sum_o = {big.sign, res_exp[EXP_W-1:0], res_frac};
        end
    end

endmodule : float_add_core

// File: rtl/arith_operator_core.sv
// -----------------------------------------------------------------------------
// arith_operator_core
// One-cycle registered arithmetic core. From a single operand pair it computes
// in parallel a Q8.8 wrap-around sum, a Q8.8 truncated product and a binary16
// truncated sum, each with its own overflow flag.
//
// Build option: define SATURATE_EN to clamp the fixed-point sum/product to
// 0x7FFF / 0x8000 on overflow (flags still assert). Float path is unaffected.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset, clears all outputs
//   in_valid   operands valid, launches a computation
//   num1, num2 [15:0] operands (Q8.8 or binary16)
//   out_valid  results valid (in_valid delayed one cycle)
//   fix_sum    [15:0] Q8.8 sum
//   fix_prod   [15:0] Q8.8 product
//   flo_sum    [15:0] binary16 sum
//   overflow   [2:0]  {float add, fixed mul, fixed add}
// -----------------------------------------------------------------------------
module arith_operator_core
    import arith_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] num1,
    input  logic [W-1:0] num2,
    output logic         out_valid,
    output logic [W-1:0] fix_sum,
    output logic [W-1:0] fix_prod,
    output logic [W-1:0] flo_sum,
    output logic [2:0]   overflow
);

    // Clamp to the most positive / most negative Q8.8 value
    function automatic logic [W-1:0] saturate_fix(input logic [W-1:0] wrapped,
                                                  input logic         ovf,
                                                  input logic         true_neg);
        if (ovf) return true_neg ? FIX_NEG_MAX : FIX_POS_MAX;
        return wrapped;
    endfunction

    logic signed [W-1:0]   a_s, b_s, sum_wrap;
    logic signed [2*W-1:0] prod_full;
    logic [W-1:0]          prod_trunc;
    logic                  add_ovf, mul_ovf, flo_ovf;
    logic [W-1:0]          flo_res;
    logic                  prod_unused;

    logic         out_valid_q;
    logic [W-1:0] fix_sum_q, fix_sum_d;
    logic [W-1:0] fix_prod_q, fix_prod_d;
    logic [W-1:0] flo_sum_q, flo_sum_d;
    logic [2:0]   ovf_q, ovf_d;

    assign a_s = $signed(num1);
    assign b_s = $signed(num2);

    // Fixed add: overflow only when like signs produce an unlike-sign result
    assign sum_wrap = a_s + b_s;
    assign add_ovf  = (a_s[W-1] == b_s[W-1]) && (sum_wrap[W-1] != a_s[W-1]);

    // Fixed multiply: Q16.16 product, keep bits [23:8]. Dropping the low byte
    // of a two's-complement value is a floor, not a round-to-zero.
    assign prod_full   = a_s * b_s;
    assign prod_trunc  = prod_full[W+FIX_FRAC-1:FIX_FRAC];
    assign mul_ovf     = !((&prod_full[2*W-1:W+FIX_FRAC-1]) || (~|prod_full[2*W-1:W+FIX_FRAC-1]));
    assign prod_unused = ^prod_full[FIX_FRAC-1:0];

    float_add_core u_float_add (
        .a_i   (num1),
        .b_i   (num2),
        .sum_o (flo_res),
        .ovf_o (flo_ovf)
    );

    always_comb begin
`ifdef SATURATE_EN
        // Add overflow implies both operands share the true result's sign
        fix_sum_d  = saturate_fix(sum_wrap, add_ovf, a_s[W-1]);
        fix_prod_d = saturate_fix(prod_trunc, mul_ovf, prod_full[2*W-1]);
`else
        fix_sum_d  = sum_wrap;
        fix_prod_d = prod_trunc;
`endif
        flo_sum_d        = flo_res;
        ovf_d            = '0;
        ovf_d[OVF_FIXA]  = add_ovf;
        ovf_d[OVF_FIXM]  = mul_ovf;
        ovf_d[OVF_FLOA]  = flo_ovf;
    end

    // Result register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            fix_sum_q   <= '0;
            fix_prod_q  <= '0;
            flo_sum_q   <= '0;
            ovf_q       <= '0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                fix_sum_q  <= fix_sum_d;
                fix_prod_q <= fix_prod_d;
                flo_sum_q  <= flo_sum_d;
                ovf_q      <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign fix_sum   = fix_sum_q;
    assign fix_prod  = fix_prod_q;
    assign flo_sum   = flo_sum_q;
    assign overflow  = ovf_q;

endmodule : arith_operator_core

// File: tb/tb_arith_operator_core.sv
// -----------------------------------------------------------------------------
// tb_arith_operator_core
// Directed bench for arith_operator_core. A value-level model (integer
// arithmetic on the numbers the operands represent) predicts every output
// cycle; literal expectations pin the key vectors.
// -----------------------------------------------------------------------------
module tb_arith_operator_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] num1, num2;
    logic        out_valid;
    logic [15:0] fix_sum, fix_prod, flo_sum;
    logic [2:0]  overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arith_operator_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .fix_sum   (fix_sum),
        .fix_prod  (fix_prod),
        .flo_sum   (flo_sum),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- value-level model ----------------
    function automatic void model_fix(input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] s, output logic [15:0] p,
                                      output logic os, output logic op);
        int     ia, ib, tsum;
        longint tp, fl;
        ia   = int'($signed(a));
        ib   = int'($signed(b));
        tsum = ia + ib;
        os   = (tsum > 32767) || (tsum < -32768);
        s    = tsum[15:0];
        tp   = longint'(ia) * longint'(ib);         // value * 2^16
        op   = (tp > 64'sd8388607) || (tp < -64'sd8388608);
        fl   = tp >>> 8;                            // floor(value * 2^8)
        p    = fl[15:0];
`ifdef SATURATE_EN
        if (os) s = (tsum > 0) ? 16'h7FFF : 16'h8000;
        if (op) p = (tp > 0) ? 16'h7FFF : 16'h8000;
`endif
    endfunction

    function automatic void model_flo(input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] r, output logic ov);
        int     ea, eb, q, e;
        longint va, vb, sum, mag, frac;
        logic   neg;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        r  = 16'h0000;
        ov = 1'b0;
        if (ea == 31 || eb == 31) begin
            r  = {(ea == 31) ? a[15] : b[15], 15'h7C00};
            ov = 1'b1;
            return;
        end
        if (ea == 0 && eb == 0) return;
        if (ea == 0) begin r = b; return; end
        if (eb == 0) begin r = a; return; end
        // Value scaled by 2^25: mantissa (with hidden one) shifted by exponent
        va = (64'd1024 + longint'(a[9:0])) <<< ea;
        vb = (64'd1024 + longint'(b[9:0])) <<< eb;
        if (a[15]) va = -va;
        if (b[15]) vb = -vb;
        if (ea - eb >= 12) vb = 0;
        if (eb - ea >= 12) va = 0;
        sum = va + vb;
        if (sum == 0) return;
        neg = (sum < 0);
        mag = neg ? -sum : sum;
        q = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) q = i;
        e = q - 10;
        if (e <= 0) return;
        if (e >= 31) begin
            r  = {neg, 15'h7C00};
            ov = 1'b1;
            return;
        end
        frac = (mag >> (q - 10)) & 64'h3FF;
        r = {neg, e[4:0], frac[9:0]};
    endfunction

    logic        m_valid;
    logic [15:0] m_sum, m_prod, m_flo;
    logic [2:0]  m_ovf;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin : model
        logic [15:0] s, p, f;
        logic        os, op, of;
        if (rst) begin
            m_valid <= 1'b0;
            m_sum   <= '0;
            m_prod  <= '0;
            m_flo   <= '0;
            m_ovf   <= '0;
            chk_en  <= 1'b1;
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                model_fix(num1, num2, s, p, os, op);
                model_flo(num1, num2, f, of);
                m_sum  <= s;
                m_prod <= p;
                m_flo  <= f;
                m_ovf  <= {of, op, os};
            end
        end
    end

    // Compare every cycle once a reset has been seen (held values matter too)
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", {15'b0, out_valid}, {15'b0, m_valid});
            check("fix_sum",   fix_sum,  m_sum);
            check("fix_prod",  fix_prod, m_prod);
            check("flo_sum",   flo_sum,  m_flo);
            check("overflow",  {13'b0, overflow}, {13'b0, m_ovf});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        num1     = a;
        num2     = b;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    logic [15:0] vec_a [12] = '{16'h4000, 16'h0000, 16'h0001, 16'h0401, 16'h8000, 16'h5640,
                                16'h6400, 16'h3C00, 16'hC500, 16'hFC00, 16'h8001, 16'h7FFF};
    logic [15:0] vec_b [12] = '{16'h0400, 16'h4500, 16'hC200, 16'h8400, 16'h8000, 16'hD240,
                                16'h1400, 16'h1000, 16'h4100, 16'h3C00, 16'h7FFF, 16'hFFFF};

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        num1     = '0;
        num2     = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {15'b0, out_valid}, 16'h0000);
        check("rst_fix_sum",   fix_sum,  16'h0000);
        check("rst_flo_sum",   flo_sum,  16'h0000);
        check("rst_overflow",  {13'b0, overflow}, 16'h0000);
        rst = 1'b0;

        drive(16'h001B, 16'h002A);
        check("v1_valid", {15'b0, out_valid}, 16'h0001);
        check("v1_sum",   fix_sum,  16'h0045);
        check("v1_prod",  fix_prod, 16'h0004);
        check("v1_ovf",   {14'b0, overflow[1:0]}, 16'h0000);
        idle();
        check("hold_valid", {15'b0, out_valid}, 16'h0000);
        check("hold_sum",   fix_sum, 16'h0045);

        drive(16'h0231, 16'h009E);
        check("v2_sum",  fix_sum,  16'h02CF);
        check("v2_prod", fix_prod, 16'h015A);
        check("v2_ovf",  {14'b0, overflow[1:0]}, 16'h0000);

        drive(16'h7F00, 16'h0100);
`ifdef SATURATE_EN
        check("v3_sum", fix_sum, 16'h7FFF);
`else
        check("v3_sum", fix_sum, 16'h8000);
`endif
        check("v3_ovf0", {15'b0, overflow[0]}, 16'h0001);

        drive(16'hFF00, 16'h0200);
        check("v4_prod", fix_prod, 16'hFE00);
        check("v4_ovf1", {15'b0, overflow[1]}, 16'h0000);

        drive(16'h3C00, 16'h3C00);
        check("f1_sum", flo_sum, 16'h4000);
        check("f1_ovf", {15'b0, overflow[2]}, 16'h0000);
        drive(16'h3C00, 16'h3800);
        check("f2_sum", flo_sum, 16'h3E00);
        check("f2_ovf", {15'b0, overflow[2]}, 16'h0000);
        drive(16'h3C00, 16'hBC00);
        check("f3_sum", flo_sum, 16'h0000);
        check("f3_ovf", {15'b0, overflow[2]}, 16'h0000);
        drive(16'h7BFF, 16'h7BFF);
        check("f4_sum", flo_sum, 16'h7C00);
        check("f4_ovf", {15'b0, overflow[2]}, 16'h0001);
        drive(16'h7C00, 16'h3C00);
        check("f5_sum", flo_sum, 16'h7C00);
        check("f5_ovf", {15'b0, overflow[2]}, 16'h0001);

        // Boundary vectors back-to-back, checked by the model
        for (int i = 0; i < 12; i++) drive(vec_a[i], vec_b[i]);
        drive(16'h0000, 16'h4500);
        check("zero_passthru", flo_sum, 16'h4500);
        drive(16'h0401, 16'h8400);
        check("flush_zero", flo_sum, 16'h0000);

        // Pseudo-random back-to-back traffic with occasional gaps
        for (int i = 0; i < 40; i++) begin
            if (i % 7 == 6) idle();
            else drive(16'($urandom), 16'($urandom));
        end

        // Reset wins over a simultaneous in_valid
        drive(16'h0100, 16'h0100);
        rst = 1'b1;
        drive(16'h1234, 16'h5678);
        check("rstv_valid", {15'b0, out_valid}, 16'h0000);
        check("rstv_sum",   fix_sum,  16'h0000);
        check("rstv_prod",  fix_prod, 16'h0000);
        check("rstv_flo",   flo_sum,  16'h0000);
        check("rstv_ovf",   {13'b0, overflow}, 16'h0000);
        rst = 1'b0;

        drive(16'h0100, 16'h0200);
        idle();
        idle();
        check("hold2_sum",  fix_sum,  16'h0300);
        check("hold2_prod", fix_prod, 16'h0200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_arith_operator_core
